// File: rtl/cache_miss_ctrl.sv
// Cache miss sequencer. Hits update the LRU one cycle after they are accepted. Misses fetch a victim from the LRU, write it back if dirty (only when CACHE_MISS_CTRL_WB_EN is defined), fill the line, then update the LRU.
// Memory beats stall on mem_ready_i. New requests are held off through req_ready_o while busy, and every output is forced low while rst_i is high.
module cache_miss_ctrl #(
    parameter int  IDX_W  = 10,
    parameter int  BEATS  = 4,
    localparam int BEAT_W = $clog2(BEATS)
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              req_valid_i,
    output logic              req_ready_o,
    input  logic              req_hit_i,
    input  logic [IDX_W-1:0]  req_idx_i,
    input  logic              victim_dirty_i,
    output logic              lru_valid_o,
    output logic              lru_hit_o,
    output logic [IDX_W-1:0]  lru_idx_o,
    input  logic              lru_valid_i,
    input  logic [IDX_W-1:0]  lru_idx_i,
    output logic              mem_valid_o,
    output logic              mem_we_o,
    output logic [IDX_W-1:0]  mem_idx_o,
    output logic [BEAT_W-1:0] mem_beat_o,
    input  logic              mem_ready_i,
    output logic              fill_we_o,
    output logic              done_o,
    output logic              busy_o
);

    typedef enum logic [2:0] {
        IDLE,
        VICTIM,
        WRITEBACK,
        FILL,
        UPDATE
    } state_t;

    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BEATS - 1);

    state_t             state_q, state_d;
    logic [BEAT_W-1:0]  beat_q, beat_d;
    logic [IDX_W-1:0]   idx_q, idx_d;

    logic               ready_c;
    logic               lru_valid_c;
    logic               lru_hit_c;
    logic [IDX_W-1:0]   lru_idx_c;
    logic               mem_valid_c;
    logic [IDX_W-1:0]   mem_idx_c;
    logic [BEAT_W-1:0]  mem_beat_c;
    logic               fill_we_c;
    logic               done_c;
    logic               busy_c;
`ifdef CACHE_MISS_CTRL_WB_EN
    logic               mem_we_c;
`else
    logic               unused_dirty;
    assign unused_dirty = victim_dirty_i;
`endif

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            beat_q  <= '0;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            beat_q  <= beat_d;
            idx_q   <= idx_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        beat_d      = beat_q;
        idx_d       = idx_q;
        ready_c     = 1'b0;
        lru_valid_c = 1'b0;
        lru_hit_c   = 1'b0;
        lru_idx_c   = '0;
        mem_valid_c = 1'b0;
        mem_idx_c   = '0;
        mem_beat_c  = '0;
        fill_we_c   = 1'b0;
        done_c      = 1'b0;
        busy_c      = (state_q != IDLE);
`ifdef CACHE_MISS_CTRL_WB_EN
        mem_we_c    = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                ready_c = 1'b1;
                if (req_valid_i) begin
                    if (req_hit_i) begin
                        idx_d   = req_idx_i;
                        state_d = UPDATE;
                    end else begin
                        state_d = VICTIM;
                    end
                end
            end
            VICTIM: begin
                lru_valid_c = 1'b1;
                if (lru_valid_i) begin
                    idx_d = lru_idx_i;
`ifdef CACHE_MISS_CTRL_WB_EN
                    state_d = victim_dirty_i ? WRITEBACK : FILL;
`else
                    state_d = FILL;
`endif
                end
            end
`ifdef CACHE_MISS_CTRL_WB_EN
            WRITEBACK: begin
                mem_valid_c = 1'b1;
                mem_we_c    = 1'b1;
                mem_idx_c   = idx_q;
                mem_beat_c  = beat_q;
                if (mem_ready_i) begin
                    beat_d = beat_q + 1'b1;
                    if (beat_q == LAST_BEAT) state_d = FILL;
                end
            end
`endif
            FILL: begin
                mem_valid_c = 1'b1;
                mem_idx_c   = idx_q;
                mem_beat_c  = beat_q;
                fill_we_c   = mem_ready_i;
                // BEATS is a power of two, so the increment wraps to 0 on the last beat
                if (mem_ready_i) begin
                    beat_d = beat_q + 1'b1;
                    if (beat_q == LAST_BEAT) state_d = UPDATE;
                end
            end
            UPDATE: begin
                lru_valid_c = 1'b1;
                lru_hit_c   = 1'b1;
                lru_idx_c   = idx_q;
                done_c      = 1'b1;
                state_d     = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Outputs are gated by rst_i so they are low throughout reset, even mid-burst
    assign req_ready_o = ready_c & ~rst_i;
    assign lru_valid_o = lru_valid_c & ~rst_i;
    assign lru_hit_o   = lru_hit_c & ~rst_i;
    assign lru_idx_o   = rst_i ? '0 : lru_idx_c;
    assign mem_valid_o = mem_valid_c & ~rst_i;
    assign mem_idx_o   = rst_i ? '0 : mem_idx_c;
    assign mem_beat_o  = rst_i ? '0 : mem_beat_c;
    assign fill_we_o   = fill_we_c & ~rst_i;
    assign done_o      = done_c & ~rst_i;
    assign busy_o      = busy_c & ~rst_i;
`ifdef CACHE_MISS_CTRL_WB_EN
    assign mem_we_o    = mem_we_c & ~rst_i;
`else
    assign mem_we_o    = 1'b0;
`endif

endmodule

// File: tb/tb_cache_miss_ctrl.sv
// Scoreboard bench for cache_miss_ctrl: each driven cycle pushes its expected outputs, and the negedge monitor pops and compares them.
module tb_cache_miss_ctrl;

    logic       clk;
    logic       rst;
    logic       rv, rh, lv, dirty, mr;
    logic [9:0] ridx, lidx;

    logic       ready_o, lru_valid_o, lru_hit_o, mem_valid_o, mem_we_o;
    logic       fill_we_o, done_o, busy_o;
    logic [9:0] lru_idx_o, mem_idx_o;
    logic [1:0] mem_beat_o;

    typedef struct packed {
        logic       ready;
        logic       busy;
        logic       done;
        logic       lru_valid;
        logic       lru_hit;
        logic [9:0] lru_idx;
        logic       mem_valid;
        logic       mem_we;
        logic [9:0] mem_idx;
        logic [1:0] mem_beat;
        logic       fill_we;
    } outs_t;

    typedef struct {
        string tag;
        outs_t v;
        outs_t m;
    } exp_t;

    exp_t  sb[$];
    outs_t obs;
    int    n_tests = 0;
    int    n_fail  = 0;

    cache_miss_ctrl dut (
        .clk_i          (clk),
        .rst_i          (rst),
        .req_valid_i    (rv),
        .req_ready_o    (ready_o),
        .req_hit_i      (rh),
        .req_idx_i      (ridx),
        .victim_dirty_i (dirty),
        .lru_valid_o    (lru_valid_o),
        .lru_hit_o      (lru_hit_o),
        .lru_idx_o      (lru_idx_o),
        .lru_valid_i    (lv),
        .lru_idx_i      (lidx),
        .mem_valid_o    (mem_valid_o),
        .mem_we_o       (mem_we_o),
        .mem_idx_o      (mem_idx_o),
        .mem_beat_o     (mem_beat_o),
        .mem_ready_i    (mr),
        .fill_we_o      (fill_we_o),
        .done_o         (done_o),
        .busy_o         (busy_o)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always_comb begin
        obs = '{ready: ready_o, busy: busy_o, done: done_o, lru_valid: lru_valid_o,
                lru_hit: lru_hit_o, lru_idx: lru_idx_o, mem_valid: mem_valid_o,
                mem_we: mem_we_o, mem_idx: mem_idx_o, mem_beat: mem_beat_o,
                fill_we: fill_we_o};
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_tests++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, want);
        end
    endtask

    function automatic outs_t o_zero();
        outs_t o;
        o = '0;
        return o;
    endfunction

    function automatic outs_t o_idle();
        outs_t o;
        o = '0;
        o.ready = 1'b1;
        return o;
    endfunction

    function automatic outs_t o_victim();
        outs_t o;
        o = '0;
        o.busy = 1'b1;
        o.lru_valid = 1'b1;
        return o;
    endfunction

    function automatic outs_t o_upd(input logic [9:0] idx);
        outs_t o;
        o = '0;
        o.busy = 1'b1;
        o.lru_valid = 1'b1;
        o.lru_hit = 1'b1;
        o.lru_idx = idx;
        o.done = 1'b1;
        return o;
    endfunction

    function automatic outs_t o_mem(input logic we, input logic [9:0] idx,
                                    input logic [1:0] beat, input logic fwe);
        outs_t o;
        o = '0;
        o.busy = 1'b1;
        o.mem_valid = 1'b1;
        o.mem_we = we;
        o.mem_idx = idx;
        o.mem_beat = beat;
        o.fill_we = fwe;
        return o;
    endfunction

    function automatic outs_t m_all();
        outs_t m;
        m = '1;
        return m;
    endfunction

    // The LRU index is a don't-care while the victim lookup is outstanding
    function automatic outs_t m_victim();
        outs_t m;
        m = '1;
        m.lru_idx = '0;
        return m;
    endfunction

    task automatic expect_out(input string tag, input outs_t v, input outs_t m);
        exp_t e;
        e.tag = tag;
        e.v = v;
        e.m = m;
        sb.push_back(e);
    endtask

    task automatic next_cyc();
        @(posedge clk);
        #1;
        rst = 1'b0; rv = 1'b0; rh = 1'b0; ridx = '0;
        lv = 1'b0; lidx = '0; dirty = 1'b0; mr = 1'b0;
    endtask

    task automatic fill_beats(input string tag, input logic we, input logic [9:0] idx);
        for (int b = 0; b < 4; b++) begin
            next_cyc();
            mr = 1'b1;
            expect_out(tag, o_mem(we, idx, 2'(b), ~we), m_all());
        end
    endtask

    task automatic start_miss(input string tag, input logic [9:0] victim, input logic d);
        next_cyc();
        rv = 1'b1; rh = 1'b0; ridx = 10'd9;
        expect_out({tag, "_accept"}, o_idle(), m_all());
        next_cyc();
        lv = 1'b1; lidx = victim; dirty = d;
        expect_out({tag, "_victim"}, o_victim(), m_victim());
    endtask

    always @(negedge clk) begin
        if (sb.size() != 0) begin
            exp_t e;
            e = sb.pop_front();
            check_eq(e.tag, 32'(obs & e.m), 32'(e.v & e.m));
        end
    end

    initial begin
        rst = 1'b1; rv = 1'b0; rh = 1'b0; ridx = '0;
        lv = 1'b0; lidx = '0; dirty = 1'b0; mr = 1'b0;

        // Reset, including a request that must be ignored while reset is held
        next_cyc(); rst = 1'b1;
        expect_out("rst_outputs", o_zero(), m_all());
        next_cyc(); rst = 1'b1; rv = 1'b1; rh = 1'b1; ridx = 10'd4;
        expect_out("rst_req_blocked", o_zero(), m_all());
        next_cyc();
        expect_out("rst_release_ready", o_idle(), m_all());

        // Hit to line 3
        next_cyc(); rv = 1'b1; rh = 1'b1; ridx = 10'd3;
        expect_out("hit_accept", o_idle(), m_all());
        next_cyc();
        expect_out("hit_update", o_upd(10'd3), m_all());
        next_cyc();
        expect_out("hit_idle", o_idle(), m_all());

        // Clean miss: LRU answers in the second VICTIM cycle; a held request is ignored
        next_cyc(); rv = 1'b1; rh = 1'b0; ridx = 10'd9;
        expect_out("clean_accept", o_idle(), m_all());
        next_cyc(); rv = 1'b1; rh = 1'b1; ridx = 10'd8;
        expect_out("clean_victim_wait", o_victim(), m_victim());
        next_cyc(); lv = 1'b1; lidx = 10'd7;
        expect_out("clean_victim_ret", o_victim(), m_victim());
        fill_beats("clean_fill", 1'b0, 10'd7);
        next_cyc();
        expect_out("clean_update", o_upd(10'd7), m_all());
        next_cyc();
        expect_out("clean_idle", o_idle(), m_all());

        // Dirty miss to victim 5
        start_miss("dirty", 10'd5, 1'b1);
`ifdef CACHE_MISS_CTRL_WB_EN
        fill_beats("dirty_wb", 1'b1, 10'd5);
`endif
        fill_beats("dirty_fill", 1'b0, 10'd5);
        next_cyc();
        expect_out("dirty_update", o_upd(10'd5), m_all());
        next_cyc();
        expect_out("dirty_idle", o_idle(), m_all());

        // Backpressure: ready alternates 0/1, each beat shown twice and written once
        start_miss("bp", 10'd2, 1'b0);
        for (int k = 0; k < 8; k++) begin
            next_cyc();
            mr = k[0];
            expect_out("bp_fill", o_mem(1'b0, 10'd2, 2'(k / 2), k[0]), m_all());
        end
        next_cyc();
        expect_out("bp_update", o_upd(10'd2), m_all());
        next_cyc();
        expect_out("bp_idle", o_idle(), m_all());

        // Reset while beat 2 of a fill is pending
        start_miss("rstmid", 10'd6, 1'b0);
        for (int b = 0; b < 2; b++) begin
            next_cyc(); mr = 1'b1;
            expect_out("rstmid_fill", o_mem(1'b0, 10'd6, 2'(b), 1'b1), m_all());
        end
        next_cyc(); mr = 1'b0;
        expect_out("rstmid_beat2", o_mem(1'b0, 10'd6, 2'd2, 1'b0), m_all());
        next_cyc(); rst = 1'b1; mr = 1'b1;
        expect_out("rstmid_zero", o_zero(), m_all());
        next_cyc(); rst = 1'b1; mr = 1'b1;
        expect_out("rstmid_zero2", o_zero(), m_all());
        next_cyc(); rv = 1'b1; rh = 1'b1; ridx = 10'd12;
        expect_out("rstmid_ready", o_idle(), m_all());
        next_cyc();
        expect_out("rstmid_hit_update", o_upd(10'd12), m_all());
        next_cyc();
        expect_out("rstmid_hit_idle", o_idle(), m_all());

        // A following miss must start its burst from beat 0
        start_miss("post", 10'd1, 1'b0);
        fill_beats("post_fill", 1'b0, 10'd1);
        next_cyc();
        expect_out("post_update", o_upd(10'd1), m_all());
        next_cyc();
        expect_out("post_idle", o_idle(), m_all());

        @(negedge clk);
        #1;
        check_eq("sb_drain", 32'(sb.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
